flop_fifo_rd: RTL and testbench
===============================

Name: flop_fifo_rd

Overview:
- Register-based synchronous FIFO whose read side drains words written by enable-gated producers.
- A producer's enabled capture acts as the push strobe. A consumer pops words in order and gets registered read data one cycle after the pop.
- Sits between a write-enabled register stage and a downstream consumer. It decouples the cycle on which data is captured from the cycle on which it is used.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- push  input  1  write request; accepted when not full, or when full and a pop is accepted in the same cycle.
- d  input  WIDTH  write data, captured on an accepted push.
- pop  input  1  read request; accepted when not empty.
- q  output  WIDTH  registered read data.
- q_valid  output  1  high for exactly one cycle after each accepted pop.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- ovf  output  1  sticky flag: a push was rejected.
- udf  output  1  sticky flag: a pop was rejected.

Behaviour:
- Reset (clk edge with rst=1):
  - q=0, q_valid=0, count=0, empty=1, full=0, ovf=0, udf=0.
  - Read and write pointers go to 0.
  - Storage contents are don't-care.
  - Reset overrides push and pop in the same cycle.
- Storage: DEPTH x WIDTH registers; wptr and rptr are AW bits each.
- Acceptance rules, evaluated on the pre-edge state:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
- Write: on push_ok, mem[wptr] <= d and wptr <= wptr+1, wrapping modulo DEPTH.
- Read: on pop_ok, q <= mem[rptr], q_valid <= 1, and rptr <= rptr+1, wrapping modulo DEPTH.
- When there is no pop_ok: q_valid <= 0 and q holds its previous value.
- Read latency: the word appears on q one clock after the pop edge. Data written on edge N can be popped on edge N+1 at the earliest; there is no same-edge bypass.
- Count:
  - Increments on push_ok alone.
  - Decrements on pop_ok alone.
  - Unchanged when both or neither are accepted.
- empty, full: combinational decodes of the registered count.
- Boundary cases:
  - Full with push and pop in the same cycle: both accepted, count stays DEPTH, ovf is not set.
  - Full with push only: push rejected, ovf <= 1, storage and pointers unchanged.
  - Empty with pop (whether or not a push is present): pop rejected, udf <= 1, q_valid <= 0. The push is accepted normally and count becomes 1.
  - Empty with push and pop in the same cycle: no bypass, the popped word is not returned that cycle.
  - Pointer wrap: pointers roll from DEPTH-1 to 0 with no bubble.
  - Reset mid-stream: all stored words are discarded, q_valid drops on the reset edge, and the next pop before any push sets udf.
- ovf and udf clear only on reset.
- Order is strictly FIFO; no word is duplicated or lost.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> q=0, q_valid=0, empty=1, full=0, count=0, ovf=udf=0.
- Fill, overflow and drain:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> full=1, count=4.
  - Push 0x55 -> ovf=1, count stays 4.
  - Pop 4 times -> q = 0x11, 0x22, 0x33, 0x44, each with a one-cycle q_valid one cycle after its pop. Then empty=1 and 0x55 never appears.
- Underflow: pop while empty -> udf=1, q_valid=0, q holds its last value, count stays 0.
- Simultaneous push and pop at full: with 4 entries stored, push 0xAA while popping -> q = oldest word, count=4, ovf=0. Draining the FIFO afterwards yields 0xAA last.
- Wrap-around stream: 12 cycles of push+pop with d = 1..12, after pre-loading 2 words -> q returns the 2 pre-loaded words, then 1..10 in order. count stays 2 and the pointers wrap 3 times.
- Reset mid-operation: after 3 pushes, assert rst for 1 cycle, then pop -> udf=1, count=0, q_valid=0.

Source files
------------

// File: rtl/flop_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : flop_fifo_rd
// Brief    : Register-based synchronous FIFO with registered, one-cycle-late
//            read data and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module flop_fifo_rd #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] d,
    input  logic             pop,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_pop_ok  = pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign w_push_ok = push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok && !rst) begin
            r_mem[r_wptr] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_q_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_q    <= r_mem[r_rptr];
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_flop_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_flop_fifo_rd
// Brief    : Scoreboard bench for flop_fifo_rd: directed scenarios plus random
//            traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_flop_fifo_rd;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             ovf;
    logic             udf;

    flop_fifo_rd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .d       (d),
        .pop     (pop),
        .q       (q),
        .q_valid (q_valid),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus last delivered word and flags.
    logic [WIDTH-1:0] m_fifo [$];
    logic [WIDTH-1:0] exp_q  [$];
    logic [WIDTH-1:0] m_q   = '0;
    logic             m_qv  = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;
    bit               checking = 1'b0;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT state mid-cycle and pops the scoreboard on q_valid.
    always @(negedge clk) begin
        if (checking) begin
            chk("q_valid", {31'b0, q_valid}, {31'b0, m_qv});
            if (q_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_q: got 0x%0h, expected no word at %0t", q, $time);
                end else begin
                    chk("q_data", q, exp_q.pop_front());
                end
            end else begin
                chk("q_hold", q, m_q);
            end
            chk("count", {29'b0, count}, m_fifo.size());
            chk("empty", {31'b0, empty}, {31'b0, (m_fifo.size() == 0)});
            chk("full",  {31'b0, full},  {31'b0, (m_fifo.size() == DEPTH)});
            chk("ovf",   {31'b0, ovf},   {31'b0, m_ovf});
            chk("udf",   {31'b0, udf},   {31'b0, m_udf});
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst  = 1'b1;
            push = 1'b0;
            pop  = 1'b0;
            @(posedge clk);
            m_fifo.delete();
            exp_q.delete();
            m_q   = '0;
            m_qv  = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            checking = 1'b1;
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic step(input logic p, input logic [WIDTH-1:0] data, input logic r);
        bit pop_ok;
        bit push_ok;
        push = p;
        d    = data;
        pop  = r;
        pop_ok  = r && (m_fifo.size() != 0);
        push_ok = p && ((m_fifo.size() < DEPTH) || pop_ok);
        @(posedge clk);
        if (pop_ok) begin
            m_q = m_fifo.pop_front();
            exp_q.push_back(m_q);
        end
        m_qv = pop_ok;
        if (push_ok) m_fifo.push_back(data);
        if (p && !push_ok) m_ovf = 1'b1;
        if (r && !pop_ok)  m_udf = 1'b1;
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset(2);
        step(0, 0, 0);

        // Fill, overflow, drain
        step(1, 32'h11, 0);
        step(1, 32'h22, 0);
        step(1, 32'h33, 0);
        step(1, 32'h44, 0);
        step(1, 32'h55, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Underflow while empty
        step(0, 0, 1);
        step(0, 0, 0);

        // Push and pop together at full
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0);
        step(1, 32'hAA, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Empty with push and pop together: no bypass
        step(1, 32'hBB, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Wrap-around stream
        do_reset(1);
        step(1, 32'hC1, 0);
        step(1, 32'hC2, 0);
        for (int i = 1; i <= 12; i++) step(1, i, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Reset mid-operation
        step(1, 32'hD1, 0);
        step(1, 32'hD2, 0);
        step(1, 32'hD3, 0);
        step(0, 0, 1);
        do_reset(1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Random traffic
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50);
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1);
        step(0, 0, 0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d words left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
